// File: rtl/hazard_control_unit.sv
// hazard_control_unit
//   Pipeline control for the hazards operand bypassing cannot cover:
//   load-use dependences (one bubble), taken-branch redirects (flush of
//   the wrong-path IF/ID and ID/EX contents) and variable-latency data
//   memory accesses (full freeze until dmem_ready).
//
// Ports
//   clk, rst_n            pipeline clock / async active-low reset
//   id_rs1_addr/_rs2_addr source registers of the ID instruction
//   id_uses_rs1/_rs2      ID instruction actually reads that source
//   ex_rd_addr            destination of the EX instruction
//   ex_mem_read           EX instruction is a load
//   ex_branch_taken       EX resolved a taken branch/jump
//   mem_access            MEM instruction issues a load/store this cycle
//   dmem_ready            data memory completes the access this cycle
//   *_write_en, *_flush   per-stage register enables and bubble inserts
//   mem_timeout_err       sticky: a memory wait reached MEM_TIMEOUT cycles
//   stall_count           cycles in which the PC was held by a stall
//   flush_count           branch flush events
//   fsm_state             00 RUN, 01 MEM_WAIT
module hazard_control_unit #(
    parameter int CNT_WIDTH   = 32,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4:0]           id_rs1_addr,
    input  logic [4:0]           id_rs2_addr,
    input  logic                 id_uses_rs1,
    input  logic                 id_uses_rs2,
    input  logic [4:0]           ex_rd_addr,
    input  logic                 ex_mem_read,
    input  logic                 ex_branch_taken,
    input  logic                 mem_access,
    input  logic                 dmem_ready,
    output logic                 pc_write_en,
    output logic                 if_id_write_en,
    output logic                 if_id_flush,
    output logic                 id_ex_write_en,
    output logic                 id_ex_flush,
    output logic                 ex_mem_write_en,
    output logic                 mem_wb_flush,
    output logic                 mem_timeout_err,
    output logic [CNT_WIDTH-1:0] stall_count,
    output logic [CNT_WIDTH-1:0] flush_count,
    output logic [1:0]           fsm_state
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01
    } state_t;

    localparam int WCW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(MEM_TIMEOUT);

    state_t         state, state_nxt;
    logic [WCW-1:0] wait_cnt, wait_nxt;

    logic mem_stall, branch, load_use, rs1_hit, rs2_hit;
    logic pc_hold, flush_evt;

    // Hazard detection
    always_comb begin
        // Once waiting, the access is still outstanding even if the MEM
        // instruction's mem_access is no longer presented.
        mem_stall = (state == MEM_WAIT) ? ~dmem_ready : (mem_access & ~dmem_ready);
        branch    = ex_branch_taken;
        rs1_hit   = id_uses_rs1 & (id_rs1_addr == ex_rd_addr);
        rs2_hit   = id_uses_rs2 & (id_rs2_addr == ex_rd_addr);
        load_use  = ex_mem_read & (ex_rd_addr != 5'd0) & (rs1_hit | rs2_hit);
        // A branch squashes the ID instruction, so its load-use is moot.
        pc_hold   = mem_stall | (~branch & load_use);
        flush_evt = ~mem_stall & branch;
    end

    // Stage controls, priority: reset > mem_stall > branch > load_use
    always_comb begin
        pc_write_en     = 1'b1;
        if_id_write_en  = 1'b1;
        if_id_flush     = 1'b0;
        id_ex_write_en  = 1'b1;
        id_ex_flush     = 1'b0;
        ex_mem_write_en = 1'b1;
        mem_wb_flush    = 1'b0;
        if (!rst_n) begin
            pc_write_en     = 1'b0;
            if_id_write_en  = 1'b0;
            if_id_flush     = 1'b1;
            id_ex_write_en  = 1'b0;
            id_ex_flush     = 1'b1;
            ex_mem_write_en = 1'b0;
            mem_wb_flush    = 1'b1;
        end else if (mem_stall) begin
            // Freeze everything up to EX/MEM; EX keeps any pending branch
            // or load-use so it is re-evaluated on release.
            pc_write_en     = 1'b0;
            if_id_write_en  = 1'b0;
            id_ex_write_en  = 1'b0;
            ex_mem_write_en = 1'b0;
            mem_wb_flush    = 1'b1;
        end else if (branch) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            pc_write_en    = 1'b0;
            if_id_write_en = 1'b0;
            id_ex_flush    = 1'b1;
        end
    end

    // Next state and wait counter
    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        case (state)
            RUN: begin
                if (mem_stall) begin
                    state_nxt = MEM_WAIT;
                    wait_nxt  = WCW'(1);
                end else begin
                    wait_nxt  = '0;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_nxt = RUN;
                    wait_nxt  = '0;
                end else if (wait_cnt != WAIT_MAX) begin
                    wait_nxt  = wait_cnt + WCW'(1);
                end
            end
            default: begin
                state_nxt = RUN;
                wait_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= RUN;
            wait_cnt        <= '0;
            mem_timeout_err <= 1'b0;
            stall_count     <= '0;
            flush_count     <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (state_nxt == MEM_WAIT && wait_nxt == WAIT_MAX)
                mem_timeout_err <= 1'b1;
            if (pc_hold)
                stall_count <= stall_count + CNT_WIDTH'(1);
            if (flush_evt)
                flush_count <= flush_count + CNT_WIDTH'(1);
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_hazard_control_unit.sv
module tb_hazard_control_unit;

    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
    logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken, mem_access, dmem_ready;
    logic pc_write_en, if_id_write_en, if_id_flush, id_ex_write_en, id_ex_flush;
    logic ex_mem_write_en, mem_wb_flush, mem_timeout_err;
    logic [31:0] stall_count, flush_count;
    logic [1:0]  fsm_state;

    always #5 clk = ~clk;

    hazard_control_unit #(.CNT_WIDTH(32), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd_addr(ex_rd_addr), .ex_mem_read(ex_mem_read),
        .ex_branch_taken(ex_branch_taken), .mem_access(mem_access),
        .dmem_ready(dmem_ready),
        .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en),
        .if_id_flush(if_id_flush), .id_ex_write_en(id_ex_write_en),
        .id_ex_flush(id_ex_flush), .ex_mem_write_en(ex_mem_write_en),
        .mem_wb_flush(mem_wb_flush), .mem_timeout_err(mem_timeout_err),
        .stall_count(stall_count), .flush_count(flush_count),
        .fsm_state(fsm_state)
    );

    // {pc_we, if_id_we, if_id_fl, id_ex_we, id_ex_fl, ex_mem_we, mem_wb_fl}
    logic [6:0] ctl;
    assign ctl = {pc_write_en, if_id_write_en, if_id_flush, id_ex_write_en,
                  id_ex_flush, ex_mem_write_en, mem_wb_flush};

    localparam logic [6:0] C_NONE  = 7'b1101010;
    localparam logic [6:0] C_LU    = 7'b0001110;
    localparam logic [6:0] C_BR    = 7'b1111110;
    localparam logic [6:0] C_MEM   = 7'b0000001;
    localparam logic [6:0] C_RESET = 7'b0010101;

    typedef struct {
        string      name;
        logic [4:0] rs1, rs2, rd;
        logic       u1, u2, mr, br, ma, rdy;
        logic [6:0] exp_ctl;
        logic       stall_inc, flush_inc;
    } vec_t;

    int n_chk  = 0;
    int n_fail = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs1, rs2, rd, input logic u1, u2, mr, br, ma, rdy);
        id_rs1_addr = rs1; id_rs2_addr = rs2; ex_rd_addr = rd;
        id_uses_rs1 = u1;  id_uses_rs2 = u2;  ex_mem_read = mr;
        ex_branch_taken = br; mem_access = ma; dmem_ready = rdy;
    endtask

    // Inputs applied at negedge, combinational controls checked 1ns later,
    // registered state checked 1ns after the following posedge.
    task automatic cycle(input string name, input logic [6:0] exp_ctl, input logic [1:0] exp_st);
        #1;
        chk({name, " ctl"}, 32'(ctl), 32'(exp_ctl));
        chk({name, " state"}, 32'(fsm_state), 32'(exp_st));
        @(posedge clk); #1;
    endtask

    task automatic chk_cnt(input string name);
        chk({name, " stall_count"}, stall_count, 32'(exp_stall));
        chk({name, " flush_count"}, flush_count, 32'(exp_flush));
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{"idle",       0, 0, 0, 0, 0, 0, 0, 0, 1, C_NONE, 0, 0};
        vecs[1] = '{"lu_rs2",     0, 5, 5, 0, 1, 1, 0, 0, 1, C_LU,   1, 0};
        vecs[2] = '{"lu_x0",      0, 0, 0, 1, 1, 1, 0, 0, 1, C_NONE, 0, 0};
        vecs[3] = '{"lu_unused",  0, 5, 5, 0, 0, 1, 0, 0, 1, C_NONE, 0, 0};
        vecs[4] = '{"lu_rs1",     7, 2, 7, 1, 0, 1, 0, 0, 1, C_LU,   1, 0};
        vecs[5] = '{"no_load",    7, 2, 7, 1, 0, 0, 0, 0, 1, C_NONE, 0, 0};
        vecs[6] = '{"br_over_lu", 0, 5, 5, 0, 1, 1, 1, 0, 1, C_BR,   0, 1};
        vecs[7] = '{"br_only",    1, 2, 3, 1, 1, 0, 1, 0, 0, C_BR,   0, 1};
        vecs[8] = '{"zero_wait",  1, 2, 3, 1, 1, 0, 0, 1, 1, C_NONE, 0, 0};
        vecs[9] = '{"lu_r31",    31, 3,31, 1, 1, 1, 0, 1, 1, C_LU,   1, 0};

        // Reset state
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        #2;
        chk("reset ctl", 32'(ctl), 32'(C_RESET));
        chk("reset state", 32'(fsm_state), 32'd0);
        chk("reset err", 32'(mem_timeout_err), 32'd0);
        chk_cnt("reset");
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        cycle("post_reset", C_NONE, 2'b00);

        // Single-cycle load-use from a clean start
        @(negedge clk);
        drive(0, 5, 5, 0, 1, 1, 0, 0, 1);
        cycle("lu_first", C_LU, 2'b00);
        exp_stall++;
        chk_cnt("lu_first");
        @(negedge clk);
        drive(0, 5, 5, 0, 1, 0, 0, 0, 1);  // load moved on to MEM
        cycle("lu_released", C_NONE, 2'b00);
        chk_cnt("lu_released");

        // Table-driven single-cycle vectors
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].u1, vecs[i].u2,
                  vecs[i].mr, vecs[i].br, vecs[i].ma, vecs[i].rdy);
            cycle(vecs[i].name, vecs[i].exp_ctl, 2'b00);
            exp_stall += int'(vecs[i].stall_inc);
            exp_flush += int'(vecs[i].flush_inc);
            chk_cnt(vecs[i].name);
        end

        // Memory wait: ready low 3 cycles, then high
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
            cycle("memwait", C_MEM, (i == 0) ? 2'b00 : 2'b01);
            exp_stall++;
        end
        chk_cnt("memwait");
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
        cycle("memwait_rel", C_NONE, 2'b01);
        chk("memwait_rel state", 32'(fsm_state), 32'd0);
        chk_cnt("memwait_rel");

        // Branch held during a 2-cycle memory stall
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive(0, 0, 0, 0, 0, 0, 1, 1, 0);
            cycle("stall_br", C_MEM, (i == 0) ? 2'b00 : 2'b01);
            exp_stall++;
        end
        chk_cnt("stall_br");
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 1, 1, 1);
        cycle("stall_br_rel", C_BR, 2'b01);
        exp_flush++;
        chk_cnt("stall_br_rel");
        chk("stall_br_rel err", 32'(mem_timeout_err), 32'd0);

        // Timeout: ready low 6 cycles, error appears once wait count hits 4
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
            cycle("timeout", C_MEM, (i == 1) ? 2'b00 : 2'b01);
            exp_stall++;
            chk($sformatf("timeout err c%0d", i), 32'(mem_timeout_err), (i >= 4) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
        cycle("timeout_rel", C_NONE, 2'b01);
        chk("timeout sticky", 32'(mem_timeout_err), 32'd1);
        chk("timeout_rel state", 32'(fsm_state), 32'd0);
        chk_cnt("timeout_rel");

        // Reset asserted mid-wait clears everything asynchronously
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
            cycle("prewait", C_MEM, (i == 0) ? 2'b00 : 2'b01);
        end
        #2;
        rst_n = 1'b0;
        #1;
        exp_stall = 0;
        exp_flush = 0;
        chk("midreset ctl", 32'(ctl), 32'(C_RESET));
        chk("midreset state", 32'(fsm_state), 32'd0);
        chk("midreset err", 32'(mem_timeout_err), 32'd0);
        chk_cnt("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        cycle("after_reset", C_NONE, 2'b00);
        chk_cnt("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
